// File: rtl/ldl_win_peak.sv
// Windowed peak/trough detector. Tracks max, min and index-of-max over a
// programmable window of accepted samples. It emits one result word per closed
// window through a one-deep valid/ready output register.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   win_len_i         samples per window (0 means 1), sampled at window start
//   flush_i           close the current window early (only effective when in_ready_o=1)
//   in_valid_i/in_ready_o/in_data_i     sample stream
//   out_valid_o/out_ready_i             result handshake
//   out_max_o/out_min_o/out_idx_o/out_cnt_o  result fields
module ldl_win_peak #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] win_len_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_max_o,
    output logic [WIDTH-1:0] out_min_o,
    output logic [CNT_W-1:0] out_idx_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_st_e;

    out_st_e          out_st_q, out_st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] acc_max_q, acc_max_d;
    logic [WIDTH-1:0] acc_min_q, acc_min_d;
    logic [CNT_W-1:0] acc_idx_q, acc_idx_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic             accept_c;
    logic             first_c;
    logic             close_c;
    logic [CNT_W-1:0] eff_len_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [WIDTH-1:0] fold_max_c;
    logic [WIDTH-1:0] fold_min_c;
    logic [CNT_W-1:0] fold_idx_c;

    // The output slot frees up in the same cycle its result is taken.
    assign in_ready_o = (out_st_q == OUT_EMPTY) || out_ready_i;
    assign accept_c   = in_valid_i && in_ready_o;
    assign first_c    = (cnt_q == '0);
    assign cnt_inc_c  = cnt_q + CNT_W'(1);

    // The window length is latched by the first sample, so the live input
    // is only looked at while the accumulator is empty.
    assign eff_len_c = first_c ? ((win_len_i == '0) ? CNT_W'(1) : win_len_i) : len_q;

    // Accumulator with the incoming sample folded in. Strict compares keep the
    // earliest index on ties.
    always_comb begin
        fold_max_c = acc_max_q;
        fold_min_c = acc_min_q;
        fold_idx_c = acc_idx_q;
        if (first_c) begin
            fold_max_c = in_data_i;
            fold_min_c = in_data_i;
            fold_idx_c = '0;
        end else begin
            if (in_data_i > acc_max_q) begin
                fold_max_c = in_data_i;
                fold_idx_c = cnt_q;
            end
            if (in_data_i < acc_min_q) begin
                fold_min_c = in_data_i;
            end
        end
    end

    // A natural close and a flush on the same edge produce a single result.
    // A flush on an empty window with no sample does nothing.
    assign close_c = in_ready_o &&
                     ((accept_c && (cnt_inc_c == eff_len_c)) ||
                      (flush_i && (!first_c || accept_c)));

    // Accumulator and output-register next state.
    always_comb begin
        out_st_d  = out_st_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;
        acc_idx_d = acc_idx_q;
        out_max_d = out_max_q;
        out_min_d = out_min_q;
        out_idx_d = out_idx_q;
        out_cnt_d = out_cnt_q;

        if (accept_c) begin
            acc_max_d = fold_max_c;
            acc_min_d = fold_min_c;
            acc_idx_d = fold_idx_c;
            cnt_d     = cnt_inc_c;
            if (first_c) begin
                len_d = eff_len_c;
            end
        end

        case (out_st_q)
            OUT_EMPTY: ;
            OUT_FULL:  if (out_ready_i) out_st_d = OUT_EMPTY;
            default:   out_st_d = OUT_EMPTY;
        endcase

        if (close_c) begin
            cnt_d     = '0;
            out_st_d  = OUT_FULL;
            out_max_d = accept_c ? fold_max_c : acc_max_q;
            out_min_d = accept_c ? fold_min_c : acc_min_q;
            out_idx_d = accept_c ? fold_idx_c : acc_idx_q;
            out_cnt_d = accept_c ? cnt_inc_c  : cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_st_q  <= OUT_EMPTY;
            cnt_q     <= '0;
            len_q     <= '0;
            acc_max_q <= '0;
            acc_min_q <= '0;
            acc_idx_q <= '0;
            out_max_q <= '0;
            out_min_q <= '0;
            out_idx_q <= '0;
            out_cnt_q <= '0;
        end else begin
            out_st_q  <= out_st_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            acc_max_q <= acc_max_d;
            acc_min_q <= acc_min_d;
            acc_idx_q <= acc_idx_d;
            out_max_q <= out_max_d;
            out_min_q <= out_min_d;
            out_idx_q <= out_idx_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign out_valid_o = (out_st_q == OUT_FULL);
    assign out_max_o   = out_max_q;
    assign out_min_o   = out_min_q;
    assign out_idx_o   = out_idx_q;
    assign out_cnt_o   = out_cnt_q;

endmodule
